// File: rtl/ram_hs_pkg.sv
// Shared types and constants for the handshaked word RAM: controller states,
// wait-counter width and the legal WAIT_STATES range.
package ram_hs_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_ACCESS = 2'd3
  } state_e;

  localparam int CNT_W           = 4;
  localparam int MAX_WAIT_STATES = (1 << CNT_W) - 1;

  function automatic bit wait_states_ok(input int ws);
    return (ws >= 0) && (ws <= MAX_WAIT_STATES);
  endfunction

endpackage

// File: rtl/ram_hs_array.sv
// DEPTH x WIDTH storage: one synchronous write port and one registered read port.
// Holds no reset; contents are initialised by the controller's clear sequence.
module ram_hs_array
  import ram_hs_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wadr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] radr,
  output logic [WIDTH-1:0]  rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] mem_r [DEPTH];

  // write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[wadr] <= wdata;
    end
  end

  // registered read port
  always_ff @(posedge clk) begin
    rdata <= mem_r[radr];
  end

endmodule

// File: rtl/ram_hs.sv
// Single-port word RAM behind a req/ready handshake with configurable wait
// states and a hardware clear-on-reset sequencer.
module ram_hs
  import ram_hs_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] adr,
  input  logic [WIDTH-1:0]  writedata,
  output logic [WIDTH-1:0]  memdata,
  output logic              ready,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_ADR  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  WAIT_INIT = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  generate
    if (!wait_states_ok(WAIT_STATES)) begin : g_bad_wait_states
      $error("ram_hs: WAIT_STATES must be within 0..15");
    end
  endgenerate

  state_e            state_r, state_s;
  logic [ADDR_W-1:0] clr_adr_r, adr_r, radr_s, wadr_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              we_r, ready_r, busy_r, accept_s, mem_we_s;
  logic [WIDTH-1:0]  wd_r, memdata_r, rdata_s, wdata_s;

  ram_hs_array #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we_s),
    .wadr  (wadr_s),
    .wdata (wdata_s),
    .radr  (radr_s),
    .rdata (rdata_s)
  );

  // next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_CLEAR: begin
        if (clr_adr_r == LAST_ADR) state_s = ST_IDLE;
        else                       state_s = ST_CLEAR;
      end
      ST_IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) state_s = ST_ACCESS;
          else                  state_s = ST_WAIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == CNT_ZERO) state_s = ST_ACCESS;
        else                   state_s = ST_WAIT;
      end
      ST_ACCESS: state_s = ST_IDLE;
      default:   state_s = ST_CLEAR;
    endcase
  end

  // array port steering; the read address follows adr on the accepting edge so
  // rdata already holds the target word by the ACCESS cycle
  always_comb begin
    accept_s = (state_r == ST_IDLE) && req;
    mem_we_s = 1'b0;
    wadr_s   = adr_r;
    wdata_s  = wd_r;
    if (reset) begin
      mem_we_s = 1'b0;
    end else if (state_r == ST_CLEAR) begin
      mem_we_s = 1'b1;
      wadr_s   = clr_adr_r;
      wdata_s  = {WIDTH{1'b0}};
    end else if (state_r == ST_ACCESS) begin
      mem_we_s = we_r;
    end else begin
      mem_we_s = 1'b0;
    end
    if (accept_s) radr_s = adr;
    else          radr_s = adr_r;
  end

  // state register and handshake flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_CLEAR;
      busy_r  <= 1'b1;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != ST_IDLE);
      ready_r <= (state_r == ST_ACCESS);
    end
  end

  // clear address counter
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_adr_r <= {ADDR_W{1'b0}};
    end else if (state_r == ST_CLEAR) begin
      clr_adr_r <= clr_adr_r + ADR_ONE;
    end
  end

  // request capture and wait-state countdown
  always_ff @(posedge clk) begin
    if (reset) begin
      we_r  <= 1'b0;
      adr_r <= {ADDR_W{1'b0}};
      wd_r  <= {WIDTH{1'b0}};
      cnt_r <= CNT_ZERO;
    end else if (accept_s) begin
      we_r  <= we;
      adr_r <= adr;
      wd_r  <= writedata;
      cnt_r <= WAIT_INIT;
    end else if (state_r == ST_WAIT) begin
      cnt_r <= cnt_r - CNT_ONE;
    end
  end

  // read data register, write-through on writes
  always_ff @(posedge clk) begin
    if (reset) begin
      memdata_r <= {WIDTH{1'b0}};
    end else if (state_r == ST_ACCESS) begin
      memdata_r <= we_r ? wd_r : rdata_s;
    end
  end

  assign memdata = memdata_r;
  assign ready   = ready_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_ram_hs.sv
// Scoreboard bench for ram_hs: default instance (8/8/2) and a small
// zero-wait instance (16/4/0) sharing clock and reset.
module tb_ram_hs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_a, we_a, ready_a, busy_a;
  logic [7:0]  adr_a, wd_a, memdata_a;
  logic        req_b, we_b, ready_b, busy_b;
  logic [3:0]  adr_b;
  logic [15:0] wd_b, memdata_b;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  logic [15:0] exp_q[$];
  int          exp_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  ram_hs #(.WIDTH(8), .ADDR_W(8), .WAIT_STATES(2)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .we(we_a), .adr(adr_a),
    .writedata(wd_a), .memdata(memdata_a), .ready(ready_a), .busy(busy_a)
  );

  ram_hs #(.WIDTH(16), .ADDR_W(4), .WAIT_STATES(0)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .we(we_b), .adr(adr_b),
    .writedata(wd_b), .memdata(memdata_b), .ready(ready_b), .busy(busy_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_issue(input logic w, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] e, input bit track);
    int n = 0;
    while (busy_a === 1'b1 && n < 400) begin tick(); n++; end
    req_a = 1'b1; we_a = w; adr_a = a; wd_a = d;
    if (track) begin
      exp_q.push_back({8'h00, e});
      exp_cyc_q.push_back(cyc + 4);
    end
    tick();
    req_a = 1'b0;
  endtask

  task automatic b_issue(input logic w, input logic [3:0] a, input logic [15:0] d,
                         input logic [15:0] e);
    int n = 0;
    while (busy_b === 1'b1 && n < 400) begin tick(); n++; end
    req_b = 1'b1; we_b = w; adr_b = a; wd_b = d;
    exp_q.push_back(e);
    exp_cyc_q.push_back(cyc + 2);
    tick();
    req_b = 1'b0;
  endtask

  task automatic wait_ready(input bit on_b, output bit seen, output int at, output logic [15:0] data);
    seen = 1'b0; at = -1; data = 16'h0000;
    for (int i = 0; i < 20; i++) begin
      if (!on_b && ready_a === 1'b1) begin seen = 1'b1; at = cyc; data = {8'h00, memdata_a}; break; end
      if (on_b && ready_b === 1'b1) begin seen = 1'b1; at = cyc; data = memdata_b; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    int  na, nb;
    bit  rdy_seen;
    reset = 1'b1; tick(); tick();
    tests_run++; if (busy_a !== 1'b1) begin tests_failed++; $display("FAIL reset_busy_a: got %b want 1", busy_a); end
    tests_run++; if (ready_a !== 1'b0) begin tests_failed++; $display("FAIL reset_ready_a: got %b want 0", ready_a); end
    tests_run++; if (memdata_a !== 8'h00) begin tests_failed++; $display("FAIL reset_memdata_a: got %h want 00", memdata_a); end
    tests_run++; if (busy_b !== 1'b1) begin tests_failed++; $display("FAIL reset_busy_b: got %b want 1", busy_b); end
    tests_run++; if (memdata_b !== 16'h0000) begin tests_failed++; $display("FAIL reset_memdata_b: got %h want 0000", memdata_b); end
    reset = 1'b0; na = 0; nb = 0; rdy_seen = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (ready_a === 1'b1 || ready_b === 1'b1) rdy_seen = 1'b1;
      if (na == 0 && busy_a === 1'b0) na = i;
      if (nb == 0 && busy_b === 1'b0) nb = i;
      if (na != 0 && nb != 0) break;
    end
    tests_run++; if (na != 256) begin tests_failed++; $display("FAIL clear_len_a: got %0d want 256", na); end
    tests_run++; if (nb != 16) begin tests_failed++; $display("FAIL clear_len_b: got %0d want 16", nb); end
    tests_run++; if (rdy_seen !== 1'b0) begin tests_failed++; $display("FAIL clear_ready: got %b want 0", rdy_seen); end
  endtask

  task automatic test_write_read();
    logic        ow[3];
    logic [7:0]  oa[3], od[3], oe[3];
    bit          seen;
    int          at, ec;
    logic [15:0] data, exp;
    ow[0] = 1'b0; oa[0] = 8'hFF; od[0] = 8'h00; oe[0] = 8'h00;
    ow[1] = 1'b1; oa[1] = 8'h10; od[1] = 8'hA5; oe[1] = 8'hA5;
    ow[2] = 1'b0; oa[2] = 8'h10; od[2] = 8'h00; oe[2] = 8'hA5;
    for (int k = 0; k < 3; k++) begin
      a_issue(ow[k], oa[k], od[k], oe[k], 1'b1);
      wait_ready(1'b0, seen, at, data);
      exp = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
      tests_run++; if (seen !== 1'b1) begin tests_failed++; $display("FAIL wr_ready_%0d: got no ready want ready", k); end
      tests_run++; if (at != ec) begin tests_failed++; $display("FAIL wr_latency_%0d: got cycle %0d want %0d", k, at, ec); end
      tests_run++; if (data !== exp) begin tests_failed++; $display("FAIL wr_data_%0d: got %h want %h", k, data, exp); end
      tick();
      tests_run++; if (ready_a !== 1'b0) begin tests_failed++; $display("FAIL wr_pulse_%0d: got %b want 0", k, ready_a); end
    end
  endtask

  task automatic test_busy_ignored();
    int          nready, at;
    bit          seen;
    logic [15:0] data, exp;
    a_issue(1'b1, 8'h11, 8'h77, 8'h77, 1'b1);
    tests_run++; if (busy_a !== 1'b1) begin tests_failed++; $display("FAIL busy_in_wait: got %b want 1", busy_a); end
    req_a = 1'b1; we_a = 1'b0; adr_a = 8'h10; wd_a = 8'hEE;
    tick();
    req_a = 1'b0;
    nready = 0;
    for (int i = 0; i < 12; i++) begin
      if (ready_a === 1'b1) begin
        nready++;
        if (nready == 1) begin
          exp = exp_q.pop_front(); at = exp_cyc_q.pop_front();
          tests_run++; if (cyc != at) begin tests_failed++; $display("FAIL ign_latency: got cycle %0d want %0d", cyc, at); end
          tests_run++; if ({8'h00, memdata_a} !== exp) begin tests_failed++; $display("FAIL ign_data: got %h want %h", memdata_a, exp[7:0]); end
        end
      end
      tick();
    end
    tests_run++; if (nready != 1) begin tests_failed++; $display("FAIL ign_ready_count: got %0d want 1", nready); end
    for (int k = 0; k < 2; k++) begin
      a_issue(1'b0, (k == 0) ? 8'h10 : 8'h11, 8'h00, (k == 0) ? 8'hA5 : 8'h77, 1'b1);
      wait_ready(1'b0, seen, at, data);
      exp = exp_q.pop_front(); void'(exp_cyc_q.pop_front());
      tests_run++; if (seen !== 1'b1 || data !== exp) begin tests_failed++; $display("FAIL ign_readback_%0d: got %h (ready %b) want %h", k, data, seen, exp); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int n = 0, nready = 0, ec;
    logic [15:0] exp;
    while (busy_a === 1'b1 && n < 400) begin tick(); n++; end
    req_a = 1'b1; we_a = 1'b0; adr_a = 8'h10; wd_a = 8'h00;
    for (int k = 1; k <= 3; k++) begin exp_q.push_back(16'h00A5); exp_cyc_q.push_back(cyc + 4 * k); end
    for (int i = 1; i <= 18; i++) begin
      tick();
      if (ready_a === 1'b1) begin
        nready++;
        if (exp_q.size() == 0) begin
          tests_run++; tests_failed++; $display("FAIL b2b_spurious: got ready at cycle %0d want none", cyc);
        end else begin
          exp = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
          tests_run++; if (cyc != ec) begin tests_failed++; $display("FAIL b2b_latency: got cycle %0d want %0d", cyc, ec); end
          tests_run++; if ({8'h00, memdata_a} !== exp) begin tests_failed++; $display("FAIL b2b_data: got %h want %h", memdata_a, exp[7:0]); end
        end
      end
      if (i == 12) req_a = 1'b0;
    end
    tests_run++; if (nready != 3) begin tests_failed++; $display("FAIL b2b_count: got %0d want 3", nready); end
    exp_q.delete(); exp_cyc_q.delete();
  endtask

  task automatic test_reset_mid_access();
    bit          seen, rdy_seen;
    int          at, ec, n;
    logic [15:0] data, exp;
    a_issue(1'b1, 8'h20, 8'h3C, 8'h3C, 1'b1);
    wait_ready(1'b0, seen, at, data);
    exp = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
    tests_run++; if (seen !== 1'b1 || at != ec || data !== exp) begin tests_failed++; $display("FAIL mid_prewrite: got %h at %0d want %h at %0d", data, at, exp, ec); end
    tick();
    a_issue(1'b1, 8'h20, 8'h5A, 8'h00, 1'b0);
    reset = 1'b1; tick(); reset = 1'b0;
    tests_run++; if (ready_a !== 1'b0 || busy_a !== 1'b1) begin tests_failed++; $display("FAIL mid_reset_flags: got ready %b busy %b want 0 1", ready_a, busy_a); end
    n = 0; rdy_seen = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (ready_a === 1'b1) rdy_seen = 1'b1;
      if (busy_a === 1'b0) begin n = i; break; end
    end
    tests_run++; if (n != 256) begin tests_failed++; $display("FAIL mid_clear_len: got %0d want 256", n); end
    tests_run++; if (rdy_seen !== 1'b0) begin tests_failed++; $display("FAIL mid_no_ready: got %b want 0", rdy_seen); end
    a_issue(1'b0, 8'h20, 8'h00, 8'h00, 1'b1);
    wait_ready(1'b0, seen, at, data);
    exp = exp_q.pop_front(); void'(exp_cyc_q.pop_front());
    tests_run++; if (seen !== 1'b1 || data !== exp) begin tests_failed++; $display("FAIL mid_readback: got %h (ready %b) want %h", data, seen, exp); end
    tick();
  endtask

  task automatic test_small();
    logic        ow[3];
    logic [3:0]  oa[3];
    logic [15:0] od[3], oe[3], data, exp;
    bit          seen;
    int          at, ec;
    ow[0] = 1'b1; oa[0] = 4'hF; od[0] = 16'hBEEF; oe[0] = 16'hBEEF;
    ow[1] = 1'b0; oa[1] = 4'hF; od[1] = 16'h0000; oe[1] = 16'hBEEF;
    ow[2] = 1'b0; oa[2] = 4'h0; od[2] = 16'h1234; oe[2] = 16'h0000;
    for (int k = 0; k < 3; k++) begin
      b_issue(ow[k], oa[k], od[k], oe[k]);
      wait_ready(1'b1, seen, at, data);
      exp = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
      tests_run++; if (at != ec) begin tests_failed++; $display("FAIL small_latency_%0d: got cycle %0d want %0d", k, at, ec); end
      tests_run++; if (data !== exp) begin tests_failed++; $display("FAIL small_data_%0d: got %h want %h", k, data, exp); end
      tick();
      tests_run++; if (ready_b !== 1'b0) begin tests_failed++; $display("FAIL small_pulse_%0d: got %b want 0", k, ready_b); end
    end
  endtask

  initial begin
    reset = 1'b1;
    req_a = 1'b0; we_a = 1'b0; adr_a = 8'h00; wd_a = 8'h00;
    req_b = 1'b0; we_b = 1'b0; adr_b = 4'h0;  wd_b = 16'h0000;
    test_reset();
    test_write_read();
    test_busy_ignored();
    test_back_to_back();
    test_reset_mid_access();
    test_small();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by %0t want finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
